// File: rtl/if_stage_reg.sv
// rtl/if_stage_reg.sv - instruction-fetch PC register, PC increment and IF/ID pipeline register
//
// Purpose: holds the fetch PC, forms pc_plus_4 for the next-PC mux, and
// captures the fetched instruction into the IF/ID register. Supports stall
// and flush, a one-cycle boot state after reset, a sticky misaligned-PC flag,
// and saturating fetch/stall counters.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   next_pc        next PC from the next-PC mux
//   pc_write       1 = advance, 0 = stall
//   flush          1 = squash IF/ID and load next_pc
//   instr_in       instruction memory data at pc_out
//   pc_out         current PC (instruction memory address)
//   pc_plus_4      pc_out + PC_INC (combinational)
//   ifid_instr     registered instruction
//   ifid_pc_plus_4 registered pc_plus_4 of that instruction
//   ifid_valid     IF/ID holds a real instruction
//   misaligned     sticky: a next_pc with nonzero bits [1:0] was loaded
//   fetch_count    instructions captured into IF/ID (saturating)
//   stall_count    stalled RUN cycles (saturating)
module if_stage_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_INC    = 32'd4,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          next_pc,
  input  logic                 pc_write,
  input  logic                 flush,
  input  logic [31:0]          instr_in,
  output logic [31:0]          pc_out,
  output logic [31:0]          pc_plus_4,
  output logic [31:0]          ifid_instr,
  output logic [31:0]          ifid_pc_plus_4,
  output logic                 ifid_valid,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] fetch_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          ifid_pc4_q, ifid_pc4_d;
  logic                 valid_q, valid_d;
  logic                 mis_q, mis_d;
  logic [CNT_WIDTH-1:0] fetch_q, fetch_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;

  logic [31:0]          pc_plus_4_w;
  logic [31:0]          next_pc_aligned;
  logic                 next_pc_mis;

  // Wraps modulo 2^32 by construction.
  assign pc_plus_4_w     = pc_q + PC_INC;
  assign next_pc_aligned = {next_pc[31:2], 2'b00};
  assign next_pc_mis     = (next_pc[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    ifid_pc4_d = ifid_pc4_q;
    valid_d    = valid_q;
    mis_d      = mis_q;
    fetch_d    = fetch_q;
    stall_d    = stall_q;

    case (state_q)
      // One idle edge after reset lets the next-PC mux settle before the first fetch.
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (flush) begin
          pc_d       = next_pc_aligned;
          instr_d    = 32'h0000_0000;
          ifid_pc4_d = 32'h0000_0000;
          valid_d    = 1'b0;
          if (next_pc_mis) mis_d = 1'b1;
        end else if (!pc_write) begin
          if (stall_q != CNT_MAX) stall_d = stall_q + CNT_ONE;
        end else begin
          pc_d       = next_pc_aligned;
          instr_d    = instr_in;
          ifid_pc4_d = pc_plus_4_w;
          valid_d    = 1'b1;
          if (next_pc_mis) mis_d = 1'b1;
          if (fetch_q != CNT_MAX) fetch_d = fetch_q + CNT_ONE;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      ifid_pc4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
      fetch_q    <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      ifid_pc4_q <= ifid_pc4_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
      fetch_q    <= fetch_d;
      stall_q    <= stall_d;
    end
  end

  assign pc_out         = pc_q;
  assign pc_plus_4      = pc_plus_4_w;
  assign ifid_instr     = instr_q;
  assign ifid_pc_plus_4 = ifid_pc4_q;
  assign ifid_valid     = valid_q;
  assign misaligned     = mis_q;
  assign fetch_count    = fetch_q;
  assign stall_count    = stall_q;

endmodule

// File: tb/tb_if_stage_reg.sv
// tb/tb_if_stage_reg.sv - directed self-checking bench for if_stage_reg
module tb_if_stage_reg;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        flush;
  logic [31:0] instr_in;
  logic        use_target;
  logic [31:0] target;

  logic [31:0] pc_out, pc_plus_4, ifid_instr, ifid_pc_plus_4;
  logic        ifid_valid, misaligned;
  logic [31:0] fetch_count, stall_count;

  logic [31:0] s_pc_out, s_pc_plus_4, s_ifid_instr, s_ifid_pc_plus_4;
  logic        s_ifid_valid, s_misaligned;
  logic [1:0]  s_fetch_count, s_stall_count;

  int tests;
  int fails;

  // Mux model: in_0 is the DUT's own pc_plus_4, in_1 a branch target.
  assign next_pc = use_target ? target : pc_plus_4;

  if_stage_reg dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .pc_write(pc_write),
    .flush(flush), .instr_in(instr_in), .pc_out(pc_out),
    .pc_plus_4(pc_plus_4), .ifid_instr(ifid_instr),
    .ifid_pc_plus_4(ifid_pc_plus_4), .ifid_valid(ifid_valid),
    .misaligned(misaligned), .fetch_count(fetch_count),
    .stall_count(stall_count)
  );

  // Narrow-counter copy driven identically, used for saturation checks.
  if_stage_reg #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .next_pc(next_pc), .pc_write(pc_write),
    .flush(flush), .instr_in(instr_in), .pc_out(s_pc_out),
    .pc_plus_4(s_pc_plus_4), .ifid_instr(s_ifid_instr),
    .ifid_pc_plus_4(s_ifid_pc_plus_4), .ifid_valid(s_ifid_valid),
    .misaligned(s_misaligned), .fetch_count(s_fetch_count),
    .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_write = 1'b1; flush = 1'b0; use_target = 1'b0;
    target = 32'h0; instr_in = 32'hA0A0_0001;
    #3;
    tests++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    tests++; if ({ifid_instr, ifid_pc_plus_4, ifid_valid} !== 65'h0) begin fails++; $display("FAIL reset_ifid got=%h/%h/%b exp=0", ifid_instr, ifid_pc_plus_4, ifid_valid); end
    tests++; if ({misaligned, fetch_count, stall_count} !== 65'h0) begin fails++; $display("FAIL reset_flags got=%b/%0d/%0d exp=0", misaligned, fetch_count, stall_count); end
    step();
    step();
    rst = 1'b1;
    step();
    tests++; if (pc_out !== 32'h0 || ifid_valid !== 1'b0 || fetch_count !== 32'd0) begin fails++; $display("FAIL boot_edge got pc=%h v=%b f=%0d exp pc=0 v=0 f=0", pc_out, ifid_valid, fetch_count); end
    step();
    tests++; if (pc_out !== 32'h4) begin fails++; $display("FAIL first_fetch_pc got=%h exp=%h", pc_out, 32'h4); end
    tests++; if (ifid_instr !== 32'hA0A0_0001 || ifid_pc_plus_4 !== 32'h4 || ifid_valid !== 1'b1) begin fails++; $display("FAIL first_fetch_ifid got=%h/%h/%b exp=a0a00001/00000004/1", ifid_instr, ifid_pc_plus_4, ifid_valid); end
    tests++; if (fetch_count !== 32'd1) begin fails++; $display("FAIL first_fetch_count got=%0d exp=1", fetch_count); end
  endtask

  task automatic test_stall();
    instr_in = 32'hB0B0_0002;
    step();
    tests++; if (pc_out !== 32'h8) begin fails++; $display("FAIL stall_pre_pc got=%h exp=%h", pc_out, 32'h8); end
    pc_write = 1'b0;
    instr_in = 32'hEEEE_EEEE;
    for (int i = 0; i < 3; i++) step();
    tests++; if (pc_out !== 32'h8) begin fails++; $display("FAIL stall_pc got=%h exp=%h", pc_out, 32'h8); end
    tests++; if (ifid_instr !== 32'hB0B0_0002 || ifid_pc_plus_4 !== 32'h8 || ifid_valid !== 1'b1) begin fails++; $display("FAIL stall_ifid got=%h/%h/%b exp=b0b00002/00000008/1", ifid_instr, ifid_pc_plus_4, ifid_valid); end
    tests++; if (stall_count !== 32'd3 || fetch_count !== 32'd2) begin fails++; $display("FAIL stall_counts got s=%0d f=%0d exp s=3 f=2", stall_count, fetch_count); end
  endtask

  task automatic test_flush();
    flush = 1'b1; pc_write = 1'b0; use_target = 1'b1; target = 32'h0000_0100;
    step();
    tests++; if (pc_out !== 32'h100) begin fails++; $display("FAIL flush_pc got=%h exp=%h", pc_out, 32'h100); end
    tests++; if (ifid_instr !== 32'h0 || ifid_pc_plus_4 !== 32'h0 || ifid_valid !== 1'b0) begin fails++; $display("FAIL flush_ifid got=%h/%h/%b exp=0/0/0", ifid_instr, ifid_pc_plus_4, ifid_valid); end
    tests++; if (stall_count !== 32'd3 || fetch_count !== 32'd2 || misaligned !== 1'b0) begin fails++; $display("FAIL flush_counts got s=%0d f=%0d m=%b exp s=3 f=2 m=0", stall_count, fetch_count, misaligned); end
    flush = 1'b0;
  endtask

  task automatic test_misaligned();
    pc_write = 1'b1; target = 32'h0000_0042; instr_in = 32'hC0C0_0003;
    step();
    tests++; if (pc_out !== 32'h40 || misaligned !== 1'b1) begin fails++; $display("FAIL mis_load got pc=%h m=%b exp pc=00000040 m=1", pc_out, misaligned); end
    tests++; if (ifid_instr !== 32'hC0C0_0003 || ifid_pc_plus_4 !== 32'h104 || fetch_count !== 32'd3) begin fails++; $display("FAIL mis_ifid got=%h/%h f=%0d exp=c0c00003/00000104 f=3", ifid_instr, ifid_pc_plus_4, fetch_count); end
    use_target = 1'b0;
    step();
    tests++; if (pc_out !== 32'h44 || misaligned !== 1'b1) begin fails++; $display("FAIL mis_sticky got pc=%h m=%b exp pc=00000044 m=1", pc_out, misaligned); end
  endtask

  task automatic test_wrap();
    use_target = 1'b1; target = 32'hFFFF_FFFC;
    step();
    tests++; if (pc_out !== 32'hFFFF_FFFC || pc_plus_4 !== 32'h0) begin fails++; $display("FAIL wrap_pc4 got pc=%h p4=%h exp pc=fffffffc p4=00000000", pc_out, pc_plus_4); end
    use_target = 1'b0; instr_in = 32'hD0D0_0004;
    step();
    tests++; if (pc_out !== 32'h0 || ifid_pc_plus_4 !== 32'h0 || ifid_instr !== 32'hD0D0_0004) begin fails++; $display("FAIL wrap_adv got pc=%h ip4=%h ii=%h exp 0/0/d0d00004", pc_out, ifid_pc_plus_4, ifid_instr); end
    tests++; if (fetch_count !== 32'd6) begin fails++; $display("FAIL wrap_fetch got=%0d exp=6", fetch_count); end
  endtask

  task automatic test_saturate();
    tests++; if (s_fetch_count !== 2'd3) begin fails++; $display("FAIL sat_fetch got=%0d exp=3", s_fetch_count); end
    pc_write = 1'b0;
    step();
    tests++; if (stall_count !== 32'd4 || s_stall_count !== 2'd3) begin fails++; $display("FAIL sat_stall got main=%0d narrow=%0d exp main=4 narrow=3", stall_count, s_stall_count); end
    pc_write = 1'b1;
  endtask

  task automatic test_async_reset();
    step();
    tests++; if (ifid_valid !== 1'b1 || fetch_count !== 32'd7) begin fails++; $display("FAIL pre_areset got v=%b f=%0d exp v=1 f=7", ifid_valid, fetch_count); end
    #2;
    rst = 1'b0;
    #1;
    tests++; if (pc_out !== 32'h0 || ifid_instr !== 32'h0 || ifid_pc_plus_4 !== 32'h0 || ifid_valid !== 1'b0) begin fails++; $display("FAIL areset_ifid got pc=%h ii=%h ip4=%h v=%b exp all 0", pc_out, ifid_instr, ifid_pc_plus_4, ifid_valid); end
    tests++; if (misaligned !== 1'b0 || fetch_count !== 32'd0 || stall_count !== 32'd0) begin fails++; $display("FAIL areset_flags got m=%b f=%0d s=%0d exp 0", misaligned, fetch_count, stall_count); end
    step();
    rst = 1'b1; instr_in = 32'hF0F0_0005;
    step();
    tests++; if (pc_out !== 32'h0 || ifid_valid !== 1'b0 || fetch_count !== 32'd0) begin fails++; $display("FAIL reboot_edge got pc=%h v=%b f=%0d exp 0/0/0", pc_out, ifid_valid, fetch_count); end
    step();
    tests++; if (pc_out !== 32'h4 || ifid_instr !== 32'hF0F0_0005 || ifid_valid !== 1'b1 || fetch_count !== 32'd1) begin fails++; $display("FAIL reboot_fetch got pc=%h ii=%h v=%b f=%0d exp 4/f0f00005/1/1", pc_out, ifid_instr, ifid_valid, fetch_count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_stall();
    test_flush();
    test_misaligned();
    test_wrap();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
